// File: rtl/handshake_driver.sv
// Buffered valid/ready transmitter: upstream words are queued and offered
// downstream in order, with a transfer counter and a sticky stall detector.
module handshake_driver #(
  parameter int WIDTH       = 5,
  parameter int DEPTH       = 4,
  parameter int STALL_LIMIT = 15
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push_valid,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   push_ready,
  output logic                   handshake_valid,
  output logic [WIDTH-1:0]       handshake_data,
  input  logic                   handshake_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             xfer_count,
  output logic                   stall_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STALL_LIMIT + 2);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_LIMIT + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [7:0]       xferCount_q, xferCount_d;
  logic [SW-1:0]    stallCnt_q, stallCnt_d;
  logic             stallErr_q, stallErr_d;
  logic             doPush, doPop;

  // Handshake outputs decode registered state only, so ready never loops back combinationally.
  assign push_ready      = (level_q < FULL_LEVEL);
  assign handshake_valid = (level_q != '0);
  assign handshake_data  = mem_q[rdPtr_q];
  assign level           = level_q;
  assign xfer_count      = xferCount_q;
  assign stall_err       = stallErr_q;

  assign doPush = push_valid & push_ready;
  assign doPop  = handshake_valid & handshake_ready;

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    level_d     = level_q;
    xferCount_d = xferCount_q;
    stallCnt_d  = stallCnt_q;

    if (doPush) wrPtr_d = wrPtr_q + PW'(1);
    if (doPop) begin
      rdPtr_d     = rdPtr_q + PW'(1);
      xferCount_d = xferCount_q + 8'd1;
    end

    case ({doPush, doPop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Counter saturates one past the limit; reaching that value marks the overrun.
    if (doPop || !handshake_valid)
      stallCnt_d = '0;
    else if (stallCnt_q != STALL_MAX)
      stallCnt_d = stallCnt_q + SW'(1);

    stallErr_d = stallErr_q | (stallCnt_d == STALL_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      xferCount_q <= '0;
      stallCnt_q  <= '0;
      stallErr_q  <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      xferCount_q <= xferCount_d;
      stallCnt_q  <= stallCnt_d;
      stallErr_q  <= stallErr_d;
    end
  end

  // Storage is left unreset; the pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (doPush && !RESET) mem_q[wrPtr_q] <= push_data;
  end

endmodule

// File: tb/tb_handshake_driver.sv
// Scoreboard bench for handshake_driver: a queue model tracks buffered words,
// occupancy, transfer count and stall flag, compared every cycle.
module tb_handshake_driver;

  localparam int WIDTH       = 5;
  localparam int DEPTH       = 4;
  localparam int STALL_LIMIT = 15;

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic                   push_valid;
  logic [WIDTH-1:0]       push_data;
  logic                   push_ready;
  logic                   handshake_valid;
  logic [WIDTH-1:0]       handshake_data;
  logic                   handshake_ready;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             xfer_count;
  logic                   stall_err;

  handshake_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .handshake_valid(handshake_valid), .handshake_data(handshake_data),
    .handshake_ready(handshake_ready),
    .level(level), .xfer_count(xfer_count), .stall_err(stall_err)
  );

  always #5 CLK = ~CLK;

  logic [WIDTH-1:0] scoreQ[$];
  int               modelXfer;
  int               modelStall;
  bit               modelErr;
  int               checkCount = 0;
  int               passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  // One clock cycle: drive inputs at the falling edge, compare outputs against
  // the model, then advance the model across the following rising edge.
  task automatic applyStimulus(input bit rst, input bit pv, input logic [WIDTH-1:0] pd, input bit hr);
    bit modelValid, willPush, willPop;
    @(negedge CLK);
    RESET           = rst;
    push_valid      = pv;
    push_data       = pd;
    handshake_ready = hr;
    #1;
    modelValid = (scoreQ.size() > 0);
    willPush   = pv && (scoreQ.size() < DEPTH);
    willPop    = modelValid && hr;
    if (!rst) begin
      checkOutput("level", 32'(level), 32'(scoreQ.size()));
      checkOutput("valid", 32'(handshake_valid), 32'(modelValid));
      checkOutput("pushReady", 32'(push_ready), 32'(scoreQ.size() < DEPTH));
      checkOutput("xferCount", 32'(xfer_count), 32'(modelXfer));
      checkOutput("stallErr", 32'(stall_err), 32'(modelErr));
      if (modelValid) checkOutput("data", 32'(handshake_data), 32'(scoreQ[0]));
    end
    if (rst) begin
      scoreQ.delete();
      modelXfer  = 0;
      modelStall = 0;
      modelErr   = 1'b0;
    end else begin
      if (willPop) begin
        void'(scoreQ.pop_front());
        modelXfer = (modelXfer + 1) % 256;
      end
      if (willPush) scoreQ.push_back(pd);
      if (willPop || !modelValid) modelStall = 0;
      else if (modelStall < STALL_LIMIT + 1) modelStall++;
      if (modelStall > STALL_LIMIT) modelErr = 1'b1;
    end
    @(posedge CLK);
  endtask

  initial begin
    RESET = 1'b1; push_valid = 1'b0; push_data = '0; handshake_ready = 1'b0;
    modelXfer = 0; modelStall = 0; modelErr = 1'b0;

    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Single word, held stable while stalled, then one pop.
    applyStimulus(0, 1, 5'h03, 0);
    repeat (5) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("singleXfer", 32'(xfer_count), 32'd1);

    // Fill to full, overflow push ignored, drain in order.
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, WIDTH'(i), 0);
    applyStimulus(0, 1, 5'h05, 0);
    repeat (4) applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("drainedLevel", 32'(level), 32'd0);

    // Concurrent push and pop at level 2.
    applyStimulus(0, 1, 5'h10, 0);
    applyStimulus(0, 1, 5'h11, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, WIDTH'(5'h12 + i), 1);
    #1 checkOutput("steadyLevel", 32'(level), 32'd2);
    checkOutput("steadyXfer", 32'(xfer_count), 32'd15);
    repeat (3) applyStimulus(0, 0, 0, 1);

    // Stall detection: 15 stalled cycles tolerated, the 16th sets the flag.
    applyStimulus(0, 1, 5'h1a, 0);
    repeat (15) applyStimulus(0, 0, 0, 0);
    #1 checkOutput("stall15", 32'(stall_err), 32'd0);
    applyStimulus(0, 0, 0, 0);
    #1 checkOutput("stall16", 32'(stall_err), 32'd1);
    repeat (4) applyStimulus(0, 0, 0, 1);
    #1 checkOutput("stallSticky", 32'(stall_err), 32'd1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    #1 checkOutput("stallCleared", 32'(stall_err), 32'd0);

    // 256 single-word transfers wrap the counter and both pointers.
    for (int i = 0; i < 256; i++) applyStimulus(0, 1, WIDTH'(i * 7 + 3), 1);
    applyStimulus(0, 0, 0, 1);
    #1 checkOutput("xferWrap", 32'(xfer_count), 32'd0);

    // Reset mid-operation with simultaneous push and pop.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, WIDTH'(5'h15 + i), 0);
    applyStimulus(1, 1, 5'h1f, 1);
    #1 checkOutput("rstLevel", 32'(level), 32'd0);
    checkOutput("rstValid", 32'(handshake_valid), 32'd0);
    checkOutput("rstXfer", 32'(xfer_count), 32'd0);
    repeat (3) applyStimulus(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      applyStimulus(0, 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) != 0));
    repeat (DEPTH + 1) applyStimulus(0, 0, 0, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/handshake_driver.md
HANDSHAKE_DRIVER -- requirements
Module: handshake_driver

Interface
- REQ-001: Parameter WIDTH, default 5, payload width in bits.
- REQ-002: Parameter DEPTH, default 4, buffer entries; a power of two, at least 2.
- REQ-003: Parameter STALL_LIMIT, default 15, consecutive stalled cycles tolerated before error.
- REQ-004: Reset is synchronous and active-high; the design has one clock, CLK.
- REQ-005: CLK  input  1  clock; all state updates on rising edge.
- REQ-006: RESET  input  1  synchronous active-high reset.
- REQ-007: push_valid  input  1  upstream offers a word this cycle.
- REQ-008: push_data  input  WIDTH  upstream word.
- REQ-009: push_ready  output  1  buffer can accept a word this cycle.
- REQ-010: handshake_valid  output  1  transmitter offers the head word downstream.
- REQ-011: handshake_data  output  WIDTH  head word.
- REQ-012: handshake_ready  input  1  downstream accepts the offered word.
- REQ-013: level  output  $clog2(DEPTH)+1  current buffer occupancy.
- REQ-014: xfer_count  output  8  count of completed downstream transfers; wraps modulo 256.
- REQ-015: stall_err  output  1  sticky flag: valid held beyond STALL_LIMIT without ready.

Function
- REQ-016: A push occurs in a cycle with push_valid=1 and push_ready=1; a pop occurs in a cycle with handshake_valid=1 and handshake_ready=1.
- REQ-017: push_ready SHALL be 1 iff level < DEPTH, decoded from registered level only; there is no combinational path from handshake_ready.
- REQ-018: handshake_valid SHALL be 1 iff level > 0; handshake_data SHALL be the oldest unpopped word.
- REQ-019: Latency: a word pushed into an empty buffer at edge t SHALL appear on handshake_valid/handshake_data in the cycle after edge t. There is no same-cycle bypass.
- REQ-020: Words leave in push order; no word is dropped or duplicated.
- REQ-021: Once handshake_valid rises, handshake_valid and handshake_data SHALL hold stable every cycle until the pop completes.
- REQ-022: Level update per edge: push only, +1; pop only, -1; push and pop together, unchanged; neither, unchanged.
- REQ-023: Full (level=DEPTH): push_ready=0, push_valid ignored; a pop in that cycle frees an entry that is visible via push_ready in the next cycle.
- REQ-024: Empty (level=0): handshake_valid=0; handshake_ready is ignored and xfer_count is unchanged.
- REQ-025: Read and write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 without gaps.
- REQ-026: xfer_count increments by 1 on each pop; 255 followed by a pop becomes 0.
- REQ-027: stall counter: cleared on a pop or when handshake_valid=0; otherwise increments, saturating at STALL_LIMIT+1.
- REQ-028: stall_err sets at the edge where the stall counter would exceed STALL_LIMIT, i.e. after STALL_LIMIT+1 consecutive cycles with valid=1 and ready=0.
- REQ-029: stall_err remains set until RESET; it does not affect data flow.

Reset
- REQ-030: While RESET=1 at an edge: level=0, pointers=0, xfer_count=0, stall counter=0, stall_err=0.
- REQ-031: Outputs after the reset edge: handshake_valid=0, push_ready=1; handshake_data content is don't-care.
- REQ-032: RESET asserted mid-operation SHALL discard all buffered words; a simultaneous push or pop at that edge has no effect.
- REQ-033: Buffer storage needs no reset.

Verification
- REQ-034: Reset, then push 0x03 once with handshake_ready=0 -> handshake_valid=1, data=0x03 from the next cycle; held stable 5 cycles; ready=1 for one cycle -> valid=0, xfer_count=1.
- REQ-035: Push 0x01,0x02,0x03,0x04 with ready=0 -> level=4, push_ready=0; a fifth push of 0x05 is ignored; ready=1 for 4 cycles -> output order 0x01..0x04, level=0.
- REQ-036: At level=2, push and pop together for 10 cycles with incrementing data -> level stays 2, order preserved, xfer_count +10.
- REQ-037: Hold valid with ready=0 -> stall_err=0 after 15 stalled cycles and 1 after 16; then ready=1 -> stall_err stays 1 until RESET.
- REQ-038: 256 single-word transfers -> xfer_count returns to 0; pointers wrap with no data corruption.
- REQ-039: Assert RESET at level=3 while push_valid=1 and handshake_ready=1 -> level=0, valid=0, xfer_count=0 next cycle; no stale word is emitted afterward.
